// File: rtl/m_ifetch.sv
// Instruction fetch: single-outstanding Wishbone reader feeding a 2-entry {word,pc} prefetch FIFO.
// Latency: ACK in cycle n -> word at head in cycle n+1; zero-wait memory sustains 1 word / 2 cycles.
// Backpressure: no new request is issued while the FIFO is full; a redirect flushes it and drops in-flight data.
module m_ifetch #(
    parameter logic [31:0] RESETPC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        ins_take,
    output logic        ins_valid,
    output logic [31:0] INSTR_D,
    output logic [31:0] ins_pc,
    output logic        CYC_O,
    output logic        STB_O,
    output logic [31:0] ADR_O,
    input  logic [31:0] DAT_I,
    input  logic        ACK_I
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] fpc, fpc_nxt;
    logic [31:0] adr;
    logic        stb;
    logic [1:0]  count, count_nxt;
    logic        rd_ptr;
    logic        wr_ptr;
    logic [31:0] word_q [2];
    logic [31:0] pc_q   [2];
    logic        push, pop;
    logic [31:0] rpc;

    assign rpc    = redirect_pc & 32'hFFFF_FFFC;
    assign pop    = ins_take && (count != 2'd0);
    // Redirect wins over a simultaneous ACK: that data belongs to the old stream.
    assign push   = (state == S_REQ) && ACK_I && !redirect;
    assign wr_ptr = rd_ptr ^ count[0];

    always_comb begin
        count_nxt = count;
        state_nxt = state;
        fpc_nxt   = fpc;
        if (redirect)
            count_nxt = 2'd0;
        else
            count_nxt = count + {1'b0, push} - {1'b0, pop};

        case (state)
            S_IDLE: begin
                if (redirect) begin
                    fpc_nxt   = rpc;
                    state_nxt = S_REQ;
                end else if (count != 2'd2) begin
                    state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                if (redirect) begin
                    fpc_nxt   = rpc;
                    state_nxt = ACK_I ? S_REQ : S_DISCARD;
                end else if (ACK_I) begin
                    fpc_nxt   = fpc + 32'd4;
                    state_nxt = (count_nxt != 2'd2) ? S_REQ : S_IDLE;
                end
            end
            S_DISCARD: begin
                if (redirect)
                    fpc_nxt = rpc;
                if (ACK_I)
                    state_nxt = S_REQ;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            fpc       <= RESETPC;
            adr       <= RESETPC;
            stb       <= 1'b0;
            count     <= 2'd0;
            rd_ptr    <= 1'b0;
            word_q[0] <= 32'd0;
            word_q[1] <= 32'd0;
            pc_q[0]   <= RESETPC;
            pc_q[1]   <= RESETPC;
        end else begin
            state <= state_nxt;
            fpc   <= fpc_nxt;
            count <= count_nxt;
            stb   <= (state_nxt != S_IDLE);
            // DISCARD keeps the old address on the bus until its ACK arrives.
            if (state_nxt == S_REQ)
                adr <= fpc_nxt;
            if (push) begin
                word_q[wr_ptr] <= DAT_I;
                pc_q[wr_ptr]   <= fpc;
            end
            if (!redirect && pop)
                rd_ptr <= ~rd_ptr;
        end
    end

    assign ins_valid = (count != 2'd0);
    assign INSTR_D   = ins_valid ? word_q[rd_ptr] : 32'd0;
    assign ins_pc    = pc_q[rd_ptr];
    assign CYC_O     = stb;
    assign STB_O     = stb;
    assign ADR_O     = adr;

endmodule

// File: tb/tb_m_ifetch.sv
module tb_m_ifetch;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, redirect, ins_take, ins_valid, CYC_O, STB_O, ACK_I;
    logic [31:0] redirect_pc, INSTR_D, ins_pc, ADR_O, DAT_I;

    logic        b_rst_n, b_redirect, b_take, b_valid, b_cyc, b_stb, b_ack;
    logic [31:0] b_rpc, b_instr, b_pc, b_adr, b_dat;

    m_ifetch dut (
        .clk(clk), .rst_n(rst_n), .redirect(redirect), .redirect_pc(redirect_pc),
        .ins_take(ins_take), .ins_valid(ins_valid), .INSTR_D(INSTR_D), .ins_pc(ins_pc),
        .CYC_O(CYC_O), .STB_O(STB_O), .ADR_O(ADR_O), .DAT_I(DAT_I), .ACK_I(ACK_I)
    );

    m_ifetch #(.RESETPC(32'hFFFF_FFF8)) dut_b (
        .clk(clk), .rst_n(b_rst_n), .redirect(b_redirect), .redirect_pc(b_rpc),
        .ins_take(b_take), .ins_valid(b_valid), .INSTR_D(b_instr), .ins_pc(b_pc),
        .CYC_O(b_cyc), .STB_O(b_stb), .ADR_O(b_adr), .DAT_I(b_dat), .ACK_I(b_ack)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: expected FIFO contents as a queue of PCs, plus the bus view.
    logic [31:0] q[$];
    logic [31:0] next_fetch;
    logic        stale, exp_stb, prev_stb, prev_ack;
    logic [31:0] prev_adr;
    int          held, ack_wait, redir_pct, take_pct;
    bit          take_all, force_redir, force_take;
    logic [31:0] force_pc;
    int          acks_cnt, taken_cnt;

    function automatic logic [31:0] dat(input logic [31:0] a);
        return a ^ 32'hA5A5_A5A5;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        q.delete();
        next_fetch = 32'h0;
        stale = 1'b0; exp_stb = 1'b0; prev_stb = 1'b0; prev_ack = 1'b0;
        prev_adr = 32'h0; held = 0;
    endtask

    // Called at a falling edge: check outputs, drive inputs, advance model, move to next falling edge.
    task automatic step();
        logic a, r, t, pop, push;
        logic [31:0] rp;
        int old_size;
        chk("valid", ins_valid, (q.size() != 0));
        if (q.size() != 0) begin
            chk("head_pc", ins_pc, q[0]);
            chk("head_data", INSTR_D, dat(q[0]));
        end else begin
            chk("data_zero", INSTR_D, 32'h0);
        end
        chk("cyc_eq_stb", CYC_O, STB_O);
        chk("stb", STB_O, exp_stb);
        if (STB_O && !stale) chk("adr", ADR_O, next_fetch);
        if (prev_stb && !prev_ack && STB_O) chk("adr_stable", ADR_O, prev_adr);

        a  = STB_O && (held >= ack_wait);
        r  = force_redir || ($urandom_range(0, 99) < redir_pct);
        if (force_redir) rp = force_pc;
        else if ($urandom_range(0, 3) == 0) rp = 32'hFFFF_FFF0 | $urandom_range(0, 15);
        else rp = $urandom_range(0, 4095);
        t  = force_take || take_all || ($urandom_range(0, 99) < take_pct);

        ACK_I = a; DAT_I = a ? dat(ADR_O) : $urandom;
        redirect = r; redirect_pc = rp; ins_take = t;

        old_size = q.size();
        pop  = t && (old_size != 0);
        push = STB_O && a && !stale && !r;
        if (STB_O && a) acks_cnt++;
        if (r) q.delete();
        else begin
            if (pop) begin void'(q.pop_front()); taken_cnt++; end
            if (push) q.push_back(next_fetch);
        end
        prev_stb = STB_O; prev_ack = a; prev_adr = ADR_O;
        exp_stb  = STB_O ? (a ? (q.size() < 2) : 1'b1) : (r || old_size < 2);
        if (r) next_fetch = {rp[31:2], 2'b00};
        else if (push) next_fetch = next_fetch + 32'd4;
        stale = STB_O && !a && (stale || r);
        held  = (STB_O && !a) ? held + 1 : 0;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic redirect_step(input logic [31:0] pc);
        force_redir = 1'b1; force_pc = pc;
        step();
        force_redir = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        logic [31:0] b_adrs[$];
        logic [31:0] b_pcs[$];
        logic [31:0] b_dats[$];
        logic [31:0] b_exp[3];
        int bh;

        rst_n = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; ins_take = 1'b0;
        ACK_I = 1'b0; DAT_I = 32'h0;
        b_rst_n = 1'b0; b_redirect = 1'b0; b_rpc = 32'h0; b_take = 1'b0; b_ack = 1'b0; b_dat = 32'h0;
        take_all = 1'b0; force_redir = 1'b0; force_take = 1'b0; force_pc = 32'h0;
        redir_pct = 0; take_pct = 0; ack_wait = 1; acks_cnt = 0; taken_cnt = 0;
        model_reset();

        repeat (3) @(negedge clk);
        chk("rst_cyc", CYC_O, 1'b0);
        chk("rst_stb", STB_O, 1'b0);
        chk("rst_adr", ADR_O, 32'h0);
        chk("rst_valid", ins_valid, 1'b0);
        chk("rst_instr", INSTR_D, 32'h0);
        chk("rst_pc", ins_pc, 32'h0);
        rst_n = 1'b1;

        // Zero-wait memory, core takes everything.
        take_all = 1'b1; ack_wait = 1; taken_cnt = 0;
        repeat (40) step();
        chk("throughput_half_rate", (taken_cnt >= 18 && taken_cnt <= 20), 1'b1);

        // Core stalls: FIFO fills and the bus goes quiet; one take allows exactly one more fetch.
        take_all = 1'b0; take_pct = 0;
        repeat (8) step();
        chk("stall_stb_low", STB_O, 1'b0);
        chk("stall_valid", ins_valid, 1'b1);
        acks_cnt = 0;
        force_take = 1'b1; step(); force_take = 1'b0;
        repeat (10) step();
        chk("one_more_fetch", acks_cnt, 1);

        // Redirect to 0x1002 with a slow (3-cycle) ACK outstanding.
        take_all = 1'b1; ack_wait = 3;
        redirect_step(32'h0000_0500);
        n = 0;
        while (!(STB_O && held == 0 && !stale) && n < 20) begin step(); n++; end
        chk("find_fresh_req", (STB_O && held == 0), 1'b1);
        redirect_step(32'h0000_1002);
        for (int i = 0; i < 3; i++) begin
            chk("redir_no_valid", ins_valid, 1'b0);
            step();
        end
        chk("redir_new_stb", STB_O, 1'b1);
        chk("redir_new_adr", ADR_O, 32'h0000_1000);
        n = 0;
        while (!ins_valid && n < 10) begin step(); n++; end
        chk("redir_word_valid", ins_valid, 1'b1);
        chk("redir_word_pc", ins_pc, 32'h0000_1000);
        chk("redir_word_data", INSTR_D, dat(32'h0000_1000));

        // Redirect + ACK + take in one cycle with one word buffered.
        take_all = 1'b0; take_pct = 0; ack_wait = 1;
        redirect_step(32'h0000_3000);
        n = 0;
        while (!(q.size() == 1 && STB_O && held >= ack_wait && !stale) && n < 20) begin step(); n++; end
        chk("rat_setup_valid", ins_valid, 1'b1);
        force_take = 1'b1;
        redirect_step(32'h0000_2000);
        force_take = 1'b0;
        chk("rat_valid", ins_valid, 1'b0);
        chk("rat_stb", STB_O, 1'b1);
        chk("rat_adr", ADR_O, 32'h0000_2000);
        repeat (4) step();

        // Randomized traffic against the model.
        take_all = 1'b0; take_pct = 60; redir_pct = 6;
        repeat (600) begin
            if (held == 0) ack_wait = $urandom_range(1, 3);
            step();
        end
        redir_pct = 0;

        // Reset in the middle of a transaction, with a stale ACK while in reset.
        ack_wait = 3; take_all = 1'b1;
        n = 0;
        while (!(STB_O && held == 0) && n < 20) begin step(); n++; end
        rst_n = 1'b0;
        #1;
        chk("midrst_stb", STB_O, 1'b0);
        chk("midrst_cyc", CYC_O, 1'b0);
        chk("midrst_valid", ins_valid, 1'b0);
        chk("midrst_adr", ADR_O, 32'h0);
        ACK_I = 1'b1; DAT_I = 32'hDEAD_BEEF; redirect = 1'b0; ins_take = 1'b0;
        repeat (2) @(negedge clk);
        chk("midrst_hold_stb", STB_O, 1'b0);
        ACK_I = 1'b0;
        rst_n = 1'b1;
        model_reset();
        ack_wait = 1;
        step();
        chk("restart_stb", STB_O, 1'b1);
        chk("restart_adr", ADR_O, 32'h0);
        repeat (12) step();

        // Second instance: fetch wraps from 0xFFFF_FFFC to 0.
        chk("b_rst_adr", b_adr, 32'hFFFF_FFF8);
        b_rst_n = 1'b1; b_take = 1'b1; bh = 0;
        repeat (16) begin
            if (b_valid) begin b_pcs.push_back(b_pc); b_dats.push_back(b_instr); end
            b_ack = b_stb && (bh >= 1);
            if (b_ack) b_adrs.push_back(b_adr);
            b_dat = dat(b_adr);
            bh = (b_stb && !b_ack) ? bh + 1 : 0;
            @(negedge clk);
        end
        b_ack = 1'b0;
        b_exp[0] = 32'hFFFF_FFF8; b_exp[1] = 32'hFFFF_FFFC; b_exp[2] = 32'h0000_0000;
        chk("b_fetch_count", (b_adrs.size() >= 3), 1'b1);
        chk("b_word_count", (b_pcs.size() >= 3), 1'b1);
        for (int i = 0; i < 3; i++) begin
            if (b_adrs.size() > i) chk("b_wrap_adr", b_adrs[i], b_exp[i]);
            if (b_pcs.size() > i) begin
                chk("b_wrap_pc", b_pcs[i], b_exp[i]);
                chk("b_wrap_data", b_dats[i], dat(b_exp[i]));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
